// File: rtl/spiking_neuron_layer_if.sv
// Spike-input / neuron-output bundle shared by a spiking_neuron_layer and its driver.
interface spiking_neuron_layer_if #(
    parameter int INPUT_COUNT  = 4,
    parameter int NEURON_COUNT = 2,
    parameter int SUM_WIDTH    = 12
);
    logic                              enable;
    logic [INPUT_COUNT-1:0]            positive_spike;
    logic [INPUT_COUNT-1:0]            negative_spike;
    logic [NEURON_COUNT-1:0]           pos_spike_out;
    logic [NEURON_COUNT-1:0]           neg_spike_out;
    logic [NEURON_COUNT*SUM_WIDTH-1:0] membrane_out;
    logic [NEURON_COUNT-1:0]           refractory_busy;

    modport master (
        output enable, positive_spike, negative_spike,
        input  pos_spike_out, neg_spike_out, membrane_out, refractory_busy
    );

    modport slave (
        input  enable, positive_spike, negative_spike,
        output pos_spike_out, neg_spike_out, membrane_out, refractory_busy
    );
endinterface

// File: rtl/spiking_neuron_layer.sv
// Layer of leaky integrate-and-fire neurons sharing one bank of bipolar spike inputs.
// Each neuron: exponential leak, saturating membrane, refractory hold, selectable post-fire reset.
module lif_neuron #(
    parameter int SUM_WIDTH     = 12,
    parameter int DELTA_WIDTH   = 11,
    parameter int POS_THRESHOLD = 10,
    parameter int NEG_THRESHOLD = -10,
    parameter int LEAK_SHIFT    = 2,
    parameter int REFRACTORY    = 2,
    parameter int RESET_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic signed [DELTA_WIDTH-1:0] delta,
    output logic                          pos_spike,
    output logic                          neg_spike,
    output logic                          busy,
    output logic signed [SUM_WIDTH-1:0]   membrane
);
    // One guard bit over the wider operand holds leak+delta and the threshold remainder.
    localparam int EW   = ((SUM_WIDTH > DELTA_WIDTH) ? SUM_WIDTH : DELTA_WIDTH) + 1;
    localparam int RW   = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam int MAXV = (1 << (SUM_WIDTH - 1)) - 1;
    localparam int MINV = -(1 << (SUM_WIDTH - 1));

    localparam logic signed [EW-1:0] V_MAX = EW'(MAXV);
    localparam logic signed [EW-1:0] V_MIN = EW'(MINV);
    localparam logic signed [EW-1:0] P_TH  = EW'(POS_THRESHOLD);
    localparam logic signed [EW-1:0] N_TH  = EW'(NEG_THRESHOLD);

    logic [RW-1:0]               cnt;
    logic signed [SUM_WIDTH-1:0] v_leak;
    logic signed [EW-1:0]        v_sum;
    logic signed [EW-1:0]        v_sat;

    always_comb begin
        v_leak = (LEAK_SHIFT == 0) ? membrane : membrane - (membrane >>> LEAK_SHIFT);
        v_sum  = EW'(v_leak) + EW'(delta);
        if (v_sum > V_MAX)      v_sat = V_MAX;
        else if (v_sum < V_MIN) v_sat = V_MIN;
        else                    v_sat = v_sum;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            membrane  <= '0;
            cnt       <= '0;
            pos_spike <= 1'b0;
            neg_spike <= 1'b0;
        end else begin
            pos_spike <= 1'b0;
            neg_spike <= 1'b0;
            if (enable) begin
                // Refractory edges freeze the membrane entirely, leak included.
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (v_sat >= P_TH) begin
                    pos_spike <= 1'b1;
                    membrane  <= (RESET_MODE == 1) ? SUM_WIDTH'(v_sat - P_TH) : '0;
                    cnt       <= RW'(REFRACTORY);
                end else if (v_sat <= N_TH) begin
                    neg_spike <= 1'b1;
                    membrane  <= (RESET_MODE == 1) ? SUM_WIDTH'(v_sat - N_TH) : '0;
                    cnt       <= RW'(REFRACTORY);
                end else begin
                    membrane  <= SUM_WIDTH'(v_sat);
                end
            end
        end
    end

    assign busy = (cnt != '0);
endmodule

module spiking_neuron_layer #(
    parameter int INPUT_COUNT   = 4,
    parameter int NEURON_COUNT  = 2,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int SUM_WIDTH     = 12,
    parameter logic signed [WEIGHT_WIDTH-1:0] WEIGHTS [NEURON_COUNT][INPUT_COUNT] =
        '{'{1, 2, 3, 4}, '{2, 2, 2, 2}},
    parameter int POS_THRESHOLD = 10,
    parameter int NEG_THRESHOLD = -10,
    parameter int LEAK_SHIFT    = 2,
    parameter int REFRACTORY    = 2,
    parameter int RESET_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    spiking_neuron_layer_if.slave  bus
);
    localparam int DELTA_WIDTH = WEIGHT_WIDTH + $clog2(INPUT_COUNT) + 1;

    logic [NEURON_COUNT-1:0][SUM_WIDTH-1:0] mem;
    logic [NEURON_COUNT-1:0]                pos;
    logic [NEURON_COUNT-1:0]                neg;
    logic [NEURON_COUNT-1:0]                busy;

    for (genvar n = 0; n < NEURON_COUNT; n++) begin : g_neuron
        logic signed [DELTA_WIDTH-1:0] delta;

        // Both bits set on one input cancel to zero.
        always_comb begin
            delta = '0;
            for (int i = 0; i < INPUT_COUNT; i++) begin
                if (bus.positive_spike[i] && !bus.negative_spike[i])
                    delta = delta + DELTA_WIDTH'(WEIGHTS[n][i]);
                else if (!bus.positive_spike[i] && bus.negative_spike[i])
                    delta = delta - DELTA_WIDTH'(WEIGHTS[n][i]);
            end
        end

        lif_neuron #(
            .SUM_WIDTH    (SUM_WIDTH),
            .DELTA_WIDTH  (DELTA_WIDTH),
            .POS_THRESHOLD(POS_THRESHOLD),
            .NEG_THRESHOLD(NEG_THRESHOLD),
            .LEAK_SHIFT   (LEAK_SHIFT),
            .REFRACTORY   (REFRACTORY),
            .RESET_MODE   (RESET_MODE)
        ) u_neuron (
            .clk      (clk),
            .reset    (reset),
            .enable   (bus.enable),
            .delta    (delta),
            .pos_spike(pos[n]),
            .neg_spike(neg[n]),
            .busy     (busy[n]),
            .membrane (mem[n])
        );
    end

    assign bus.pos_spike_out   = pos;
    assign bus.neg_spike_out   = neg;
    assign bus.refractory_busy = busy;
    assign bus.membrane_out    = mem;
endmodule

// File: tb/tb_spiking_neuron_layer.sv
// Three layer configurations driven in lockstep and checked against an arithmetic LIF model.
module tb_spiking_neuron_layer;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] pin;
    logic [3:0] nin;

    int total = 0;
    int bad   = 0;

    // a: defaults, b: narrow saturating membrane, c: subtract-threshold reset without leak
    localparam int C_SW  [3] = '{12, 6, 12};
    localparam int C_POS [3] = '{10, 31, 10};
    localparam int C_NEG [3] = '{-10, -10, -10};
    localparam int C_LS  [3] = '{2, 0, 0};
    localparam int C_REF [3] = '{2, 2, 2};
    localparam int C_RM  [3] = '{0, 0, 1};
    int w [2][4] = '{'{1, 2, 3, 4}, '{2, 2, 2, 2}};

    int m_mem [3][2];
    int m_cnt [3][2];
    int m_pos [3][2];
    int m_neg [3][2];

    spiking_neuron_layer_if #(.INPUT_COUNT(4), .NEURON_COUNT(2), .SUM_WIDTH(12)) ifa ();
    spiking_neuron_layer_if #(.INPUT_COUNT(4), .NEURON_COUNT(2), .SUM_WIDTH(6))  ifb ();
    spiking_neuron_layer_if #(.INPUT_COUNT(4), .NEURON_COUNT(2), .SUM_WIDTH(12)) ifc ();

    assign ifa.enable = enable; assign ifa.positive_spike = pin; assign ifa.negative_spike = nin;
    assign ifb.enable = enable; assign ifb.positive_spike = pin; assign ifb.negative_spike = nin;
    assign ifc.enable = enable; assign ifc.positive_spike = pin; assign ifc.negative_spike = nin;

    spiking_neuron_layer dut_a (.clk(clk), .reset(reset), .bus(ifa));
    spiking_neuron_layer #(.SUM_WIDTH(6), .POS_THRESHOLD(31), .LEAK_SHIFT(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    spiking_neuron_layer #(.LEAK_SHIFT(0), .RESET_MODE(1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int get_mem(input int d, input int k);
        case (d)
            0:       return (k == 0) ? int'($signed(ifa.membrane_out[11:0])) : int'($signed(ifa.membrane_out[23:12]));
            1:       return (k == 0) ? int'($signed(ifb.membrane_out[5:0]))  : int'($signed(ifb.membrane_out[11:6]));
            default: return (k == 0) ? int'($signed(ifc.membrane_out[11:0])) : int'($signed(ifc.membrane_out[23:12]));
        endcase
    endfunction

    function automatic int get_vec(input int d, input int which);
        logic [1:0] v;
        case (d)
            0:       v = (which == 0) ? ifa.pos_spike_out : (which == 1) ? ifa.neg_spike_out : ifa.refractory_busy;
            1:       v = (which == 0) ? ifb.pos_spike_out : (which == 1) ? ifb.neg_spike_out : ifb.refractory_busy;
            default: v = (which == 0) ? ifc.pos_spike_out : (which == 1) ? ifc.neg_spike_out : ifc.refractory_busy;
        endcase
        return int'(v);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [3:0] p, input logic [3:0] n);
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 2; k++) begin
                m_pos[d][k] = 0;
                m_neg[d][k] = 0;
                if (!r) begin
                    m_mem[d][k] = 0;
                    m_cnt[d][k] = 0;
                end else if (e) begin
                    if (m_cnt[d][k] > 0) begin
                        m_cnt[d][k]--;
                    end else begin
                        int delta, v, vn, hi, lo;
                        delta = 0;
                        for (int i = 0; i < 4; i++)
                            delta += w[k][i] * (int'(p[i]) - int'(n[i]));
                        v  = m_mem[d][k];
                        vn = (C_LS[d] == 0) ? v : v - (v >>> C_LS[d]);
                        vn += delta;
                        hi = (1 << (C_SW[d] - 1)) - 1;
                        lo = -(1 << (C_SW[d] - 1));
                        if (vn > hi) vn = hi;
                        if (vn < lo) vn = lo;
                        if (vn >= C_POS[d]) begin
                            m_pos[d][k] = 1;
                            m_mem[d][k] = (C_RM[d] == 1) ? vn - C_POS[d] : 0;
                            m_cnt[d][k] = C_REF[d];
                        end else if (vn <= C_NEG[d]) begin
                            m_neg[d][k] = 1;
                            m_mem[d][k] = (C_RM[d] == 1) ? vn - C_NEG[d] : 0;
                            m_cnt[d][k] = C_REF[d];
                        end else begin
                            m_mem[d][k] = vn;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d pos", ph, d),  get_vec(d, 0), m_pos[d][1] * 2 + m_pos[d][0]);
            chk($sformatf("%s d%0d neg", ph, d),  get_vec(d, 1), m_neg[d][1] * 2 + m_neg[d][0]);
            chk($sformatf("%s d%0d busy", ph, d), get_vec(d, 2),
                (m_cnt[d][1] > 0 ? 2 : 0) + (m_cnt[d][0] > 0 ? 1 : 0));
            chk($sformatf("%s d%0d mem0", ph, d), get_mem(d, 0), m_mem[d][0]);
            chk($sformatf("%s d%0d mem1", ph, d), get_mem(d, 1), m_mem[d][1]);
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic [3:0] p, input logic [3:0] n, input string ph);
        reset  = r;
        enable = e;
        pin    = p;
        nin    = n;
        @(posedge clk);
        model_step(r, e, p, n);
        #1;
        check_all(ph);
    endtask

    int seq1 [5] = '{6, 5, 4, 3, 3};

    initial begin
        reset = 1'b0; enable = 1'b1; pin = '0; nin = '0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 2; k++) begin
                m_mem[d][k] = 0; m_cnt[d][k] = 0; m_pos[d][k] = 0; m_neg[d][k] = 0;
            end

        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'b1111, 4'b0000, "rst");
        chk("rst busy", get_vec(0, 2), 0);
        chk("rst mem1", get_mem(0, 1), 0);

        tick(1'b1, 1'b1, 4'b1111, 4'b0000, "fire");
        chk("fire pos0", get_vec(0, 0), 1);
        chk("fire mem1", get_mem(0, 1), 8);
        chk("fire busy0", get_vec(0, 2), 1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 4'b0000, 4'b0000, "leak");
            chk($sformatf("leak mem1 %0d", i), get_mem(0, 1), seq1[i]);
        end

        tick(1'b0, 1'b1, 4'b0000, 4'b0000, "rst");
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b1, 4'b1111, 4'b0000, "refr");
            chk($sformatf("refr pos e%0d", i), get_vec(0, 0), (i == 1) ? 1 : (i == 2) ? 2 : (i == 4) ? 1 : 0);
        end

        tick(1'b0, 1'b1, 4'b0000, 4'b0000, "rst");
        tick(1'b1, 1'b1, 4'b0000, 4'b1111, "neg");
        chk("neg neg0", get_vec(0, 1), 1);
        chk("neg mem1", get_mem(0, 1), -8);
        tick(1'b1, 1'b1, 4'b0000, 4'b0000, "neg");
        chk("neg leak mem1", get_mem(0, 1), -6);
        tick(1'b1, 1'b1, 4'b1111, 4'b1111, "both");
        chk("both mem1", get_mem(0, 1), -4);

        tick(1'b0, 1'b1, 4'b0000, 4'b0000, "rst");
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, 1'b1, 4'b1111, 4'b0000, "sat");
            chk($sformatf("sat mem0 e%0d", i), get_mem(1, 0), 10 * i);
        end
        tick(1'b1, 1'b1, 4'b1111, 4'b0000, "sat");
        chk("sat pos0", get_vec(1, 0) & 1, 1);
        chk("sat mem0 after", get_mem(1, 0), 0);

        tick(1'b0, 1'b1, 4'b0000, 4'b0000, "rst");
        tick(1'b1, 1'b1, 4'b0111, 4'b0000, "rm1");
        chk("rm1 mem0 6", get_mem(2, 0), 6);
        tick(1'b1, 1'b1, 4'b0111, 4'b0000, "rm1");
        chk("rm1 pos0", get_vec(2, 0) & 1, 1);
        chk("rm1 remainder", get_mem(2, 0), 2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 4'b1111, 4'b0000, "dis");
            chk("dis mem0", get_mem(2, 0), 2);
            chk("dis busy0", get_vec(2, 2) & 1, 1);
        end
        tick(1'b1, 1'b1, 4'b1111, 4'b0000, "resume");
        chk("resume busy0", get_vec(2, 2) & 1, 1);
        tick(1'b0, 1'b1, 4'b1111, 4'b0000, "midrst");
        chk("midrst busy", get_vec(2, 2), 0);
        chk("midrst mem0", get_mem(2, 0), 0);

        for (int i = 0; i < 400; i++) begin
            logic r, e;
            r = ($urandom_range(0, 49) != 0);
            e = ($urandom_range(0, 5) != 0);
            tick(r, e, 4'($urandom), 4'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spiking_neuron_layer.md
# spiking_neuron_layer

Parametrised layer of leaky integrate-and-fire (LIF) neurons that share one bank of bipolar spike inputs. It is the successor to the single `spiking_neuron`, and adds:
- multiple neurons with per-neuron signed weights;
- exponential leak;
- saturating membrane arithmetic;
- a refractory period and selectable post-fire reset mode;
- a global enable.

It sits between spike-encoding front ends and the next layer or the classifier output logic.

## Interface
- `INPUT_COUNT`, 4, number of shared input synapses
- `NEURON_COUNT`, 2, number of neurons in the layer
- `WEIGHT_WIDTH`, 8, signed weight width
- `SUM_WIDTH`, 12, signed membrane width; range [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1]
- `WEIGHTS`, '{'{1,2,3,4},'{2,2,2,2}}, signed weights, indexed [neuron][input]
- `POS_THRESHOLD`, 10, positive fire threshold; must lie in the membrane range
- `NEG_THRESHOLD`, -10, negative fire threshold; must lie in the membrane range
- `LEAK_SHIFT`, 2, leak shift amount; 0 disables leak
- `REFRACTORY`, 2, number of enabled cycles each neuron ignores input after firing; 0 means none
- `RESET_MODE`, 0, post-fire membrane: 0 = clear to zero, 1 = subtract the crossed threshold
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low; low at a rising edge resets all state
- `enable`  in  1  when high, the layer integrates this cycle
- `positive_spike`  in  INPUT_COUNT  excitatory spike per input
- `negative_spike`  in  INPUT_COUNT  inhibitory spike per input
- `pos_spike_out`  out  NEURON_COUNT  registered one-cycle positive spike per neuron
- `neg_spike_out`  out  NEURON_COUNT  registered one-cycle negative spike per neuron
- `membrane_out`  out  NEURON_COUNT*SUM_WIDTH  registered signed membrane; neuron n occupies bits [n*SUM_WIDTH +: SUM_WIDTH]
- `refractory_busy`  out  NEURON_COUNT  high while that neuron's refractory counter is nonzero

## Operation
Each rising edge, each neuron n with `enable`=1 and `reset`=1 updates as follows.
- **Refractory neuron** (counter > 0):
  - Decrement the counter.
  - Ignore the inputs; the membrane holds with no leak.
  - Both spike outputs are 0.
- **Otherwise (normal update):**
  - Input delta: sum over i of `WEIGHTS[n][i]`×(`positive_spike[i]` − `negative_spike[i]`). An input with both bits set contributes 0.
  - Compute the delta at full width, which is at least WEIGHT_WIDTH+clog2(INPUT_COUNT)+1 bits, so it never overflows.
  - Leak: `v_l = v − (v >>> LEAK_SHIFT)`, using an arithmetic shift. With LEAK_SHIFT=0, `v_l = v`.
  - `v_next = sat(v_l + delta)`, clamped to the membrane range.
- **Fire positive:** if `v_next >= POS_THRESHOLD`:
  - `pos_spike_out[n]`=1.
  - Membrane becomes 0 (RESET_MODE 0) or `v_next − POS_THRESHOLD` (RESET_MODE 1).
  - Counter is loaded with REFRACTORY.
- **Fire negative:** else if `v_next <= NEG_THRESHOLD`:
  - `neg_spike_out[n]`=1.
  - Membrane becomes 0 or `v_next − NEG_THRESHOLD`.
  - Counter is loaded with REFRACTORY.
- **No fire:** membrane = `v_next`, spike outputs 0.
- **`enable`=0:** membrane and counter hold, and all spike outputs are 0.
- **`reset`=0:** overrides `enable`. Membrane, counter and all outputs go to 0.
- Neurons are fully independent. No arbitration is needed.

## Timing
- Reset values: `pos_spike_out`, `neg_spike_out`, `refractory_busy` = 0; `membrane_out` = 0.
- Latency is one cycle. Inputs sampled at edge k produce spikes and the new membrane after edge k. Spikes are high for exactly one cycle.
- Refractory:
  - After a firing edge k, the next REFRACTORY enabled edges are ignored.
  - The first integrating edge is the (REFRACTORY+1)th enabled edge after k.
  - `refractory_busy` is high from edge k until the edge that decrements the counter to 0.
- Disabled cycles do not advance the refractory counter or the leak.
- `reset` asserted mid-refractory or mid-integration clears everything at that edge. The first edge after release integrates normally.

## Test plan
1. **Reset:** `reset`=0 for 3 edges with `positive_spike`=4'b1111 → all spike outputs 0, membranes 0, `refractory_busy` 0.
2. **Fire, integrate and leak (defaults):**
   - Stimulus: `positive_spike`=4'b1111 for one edge, then 0.
   - Neuron 0: delta 10 → `pos_spike_out[0]` pulses once, membrane0 0, `refractory_busy[0]` high for 2 cycles.
   - Neuron 1: membrane1 follows 8, 6, 5, 4, 3, 3, with no spike.
3. **Refractory (defaults):**
   - Stimulus: `positive_spike`=4'b1111 held for 4 edges.
   - Neuron 0 fires at edges 1 and 4.
   - Neuron 1 reaches 8 at edge 1, then fires at edge 2 (6+8=14), then is ignored at edges 3 and 4.
4. **Negative input (defaults):**
   - Stimulus: `negative_spike`=4'b1111 for one edge.
   - Neuron 0: `neg_spike_out[0]` pulses.
   - Neuron 1: membrane1 −8, then −6 after one leak edge.
   - Also drive `positive_spike`=`negative_spike`=4'b1111 → no change beyond leak.
5. **Saturation** (SUM_WIDTH=6, POS_THRESHOLD=31, LEAK_SHIFT=0):
   - Stimulus: `positive_spike`=4'b1111 on 4 edges.
   - membrane0 goes 10, 20, 30. At the 4th edge it clamps to 31 and fires, then the membrane is 0.
6. **RESET_MODE=1, enable and reset** (LEAK_SHIFT=0, REFRACTORY=2):
   - Drive `positive_spike`=4'b0111 for 2 edges → membrane0 6, then fire with remainder 2.
   - Drop `enable` for 3 edges with inputs 4'b1111 → membrane0 stays 2, busy stays high, no spikes.
   - Raise `enable` → counter resumes.
   - `reset`=0 mid-refractory → all state 0.
